// File: rtl/direction_button_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dir_ctrl_pkg
// Description : Shared types and constants for the direction button
//               controller and the odd up/down counter it feeds.
// Revision    : 1.0 - initial release
// ============================================================================
package dir_ctrl_pkg;

  // Debounce FSM states; every 2-bit code is named so no encoding is left over.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Direction levels understood by the counter.
  localparam logic Y_UP   = 1'b1;
  localparam logic Y_DOWN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/direction_button_ctrl_sync_ff_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff_chain
// Description : Plain flip-flop synchroniser for one asynchronous input.
//               The first stage may go metastable; later stages give it time
//               to settle before q is used by synchronous logic.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the chain; bit 0 samples d.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/direction_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : direction_button_ctrl
// Description : Turns a bouncy asynchronous push-button into a clean
//               direction level Y for the up/down counter. The button is
//               synchronised, debounced by a 4-state FSM, and Y toggles once
//               per accepted press. Also provides a one-cycle press pulse and
//               the debounced button level.
// Revision    : 1.0 - initial release
// ============================================================================
module direction_button_ctrl
  import dir_ctrl_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter logic Y_RESET         = Y_UP
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic Y,
  output logic press_pulse,
  output logic btn_db
);

  // Counter sized to hold DEBOUNCE_CYCLES; it only ever counts up to
  // DEBOUNCE_CYCLES-1 before the FSM leaves the wait state.
  localparam int                c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;

  logic               w_btn_s;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_y;
  logic               r_press_pulse;
  logic               r_btn_db;

  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [c_cnt_w-1:0] w_cnt_inc;
  logic               w_y_nxt;
  logic               w_pulse_nxt;
  logic               w_db_nxt;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (w_btn_s)
  );

  // Saturating increment: the count can never wrap back into a short window.
  assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : (r_cnt + c_cnt_one);

  // Next-state, counter and output decode for the debounce FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_y_nxt     = r_y;
    w_pulse_nxt = 1'b0;
    w_db_nxt    = r_btn_db;

    case (r_state)
      IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = c_cnt_one;
        end else begin
          w_cnt_nxt   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!w_btn_s) begin
          // Glitch: fall back without touching any output.
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= c_cnt_last) begin
          // Press accepted: the only place Y is allowed to change.
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_y_nxt     = ~r_y;
          w_pulse_nxt = 1'b1;
          w_db_nxt    = 1'b1;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end

      PRESSED: begin
        if (!w_btn_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = c_cnt_one;
        end else begin
          w_cnt_nxt   = '0;
        end
      end

      RELEASE_WAIT: begin
        if (w_btn_s) begin
          // Release bounce: still held, no new press is generated.
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= c_cnt_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_db_nxt    = 1'b0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops any pending toggle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_y           <= Y_RESET;
      r_press_pulse <= 1'b0;
      r_btn_db      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_y           <= w_y_nxt;
      r_press_pulse <= w_pulse_nxt;
      r_btn_db      <= w_db_nxt;
    end
  end

  assign Y           = r_y;
  assign press_pulse = r_press_pulse;
  assign btn_db      = r_btn_db;

endmodule
`default_nettype wire

// File: tb/tb_direction_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_direction_button_ctrl
// Description : Self-checking bench for direction_button_ctrl. Instance A uses
//               default parameters, instance B uses DEBOUNCE_CYCLES=8,
//               SYNC_STAGES=3, Y_RESET=0. Expected press pulses (cycle and
//               new Y) are queued when stimulus is driven and matched by
//               per-instance monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_direction_button_ctrl;

  // Press-to-toggle latency in edges: SYNC_STAGES + DEBOUNCE_CYCLES.
  localparam int LAT_A = 6;
  localparam int LAT_B = 11;

  typedef struct {
    int   cyc;
    logic y;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] bits;   // btn_raw per cycle, bit 0 first
    int          len;
    int          trig;   // index of the sample that starts the accepted press
    int          trig2;  // second accepted press, -1 if none
  } vec_t;

  logic clk = 1'b0;
  int   cyc = 0;

  logic rst_a, btn_a, y_a, pulse_a, db_a;
  logic rst_b, btn_b, y_b, pulse_b, db_b;

  int   checks = 0;
  int   errors = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  logic exp_y_a = 1'b1;
  logic exp_y_b = 1'b0;

  logic prev_pulse_a = 1'b0, prev_y_a = 1'b1;
  logic prev_pulse_b = 1'b0, prev_y_b = 1'b0;

  vec_t vecs[7];

  direction_button_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2),
    .Y_RESET         (1'b1)
  ) u_dut_a (
    .clk         (clk),
    .reset       (rst_a),
    .btn_raw     (btn_a),
    .Y           (y_a),
    .press_pulse (pulse_a),
    .btn_db      (db_a)
  );

  direction_button_ctrl #(
    .DEBOUNCE_CYCLES (8),
    .SYNC_STAGES     (3),
    .Y_RESET         (1'b0)
  ) u_dut_b (
    .clk         (clk),
    .reset       (rst_b),
    .btn_raw     (btn_b),
    .Y           (y_b),
    .press_pulse (pulse_b),
    .btn_db      (db_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic push_a(input int when);
    exp_t e;
    exp_y_a = ~exp_y_a;
    e.cyc = when;
    e.y   = exp_y_a;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int when);
    exp_t e;
    exp_y_b = ~exp_y_b;
    e.cyc = when;
    e.y   = exp_y_b;
    q_b.push_back(e);
  endtask

  // Monitor A: every pulse must match the next queued expectation, pulses
  // never come back-to-back, and Y only moves together with a pulse.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_a) begin
      if (pulse_a) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL pulse_a_unexpected: actual=1 required=0 cyc=%0d", cyc);
        end else begin
          e = q_a.pop_front();
          if (e.cyc != cyc || y_a !== e.y) begin
            errors++;
            $display("FAIL pulse_a: actual cyc=%0d Y=%0d required cyc=%0d Y=%0d",
                     cyc, y_a, e.cyc, e.y);
          end
        end
        checks++;
        if (prev_pulse_a) begin
          errors++;
          $display("FAIL pulse_a_double: actual=1 required=0 cyc=%0d", cyc);
        end
      end
      if (y_a !== prev_y_a) begin
        checks++;
        if (!pulse_a) begin
          errors++;
          $display("FAIL y_a_stable: actual=%0d required=%0d cyc=%0d", y_a, prev_y_a, cyc);
        end
      end
    end
    prev_pulse_a = pulse_a;
    prev_y_a     = y_a;
  end

  // Monitor B: same rules for the swept-parameter instance.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_b) begin
      if (pulse_b) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL pulse_b_unexpected: actual=1 required=0 cyc=%0d", cyc);
        end else begin
          e = q_b.pop_front();
          if (e.cyc != cyc || y_b !== e.y) begin
            errors++;
            $display("FAIL pulse_b: actual cyc=%0d Y=%0d required cyc=%0d Y=%0d",
                     cyc, y_b, e.cyc, e.y);
          end
        end
        checks++;
        if (prev_pulse_b) begin
          errors++;
          $display("FAIL pulse_b_double: actual=1 required=0 cyc=%0d", cyc);
        end
      end
      if (y_b !== prev_y_b) begin
        checks++;
        if (!pulse_b) begin
          errors++;
          $display("FAIL y_b_stable: actual=%0d required=%0d cyc=%0d", y_b, prev_y_b, cyc);
        end
      end
    end
    prev_pulse_b = pulse_b;
    prev_y_b     = y_b;
  end

  // Drive one vector on instance A, let it settle released, then check.
  task automatic apply_vec(input vec_t v);
    for (int i = 0; i < v.len; i++) begin
      @(negedge clk);
      if (i == v.trig || i == v.trig2) push_a(cyc + LAT_A);
      btn_a = v.bits[i];
    end
    repeat (20) begin
      @(negedge clk);
      btn_a = 1'b0;
    end
    @(posedge clk);
    #1;
    check({v.name, "_btn_db"}, {31'd0, db_a}, 32'd0);
    check({v.name, "_y"}, {31'd0, y_a}, {31'd0, exp_y_a});
    check({v.name, "_missing_pulse"}, q_a.size(), 32'd0);
    q_a.delete();
  endtask

  initial begin
    int c;
    int d;

    vecs[0] = '{"idle",          32'h0000_0000, 20, -1, -1};
    vecs[1] = '{"clean_press",   32'h000F_FFFF, 20,  0, -1};
    vecs[2] = '{"bounce_press",  32'h000F_FFED, 20,  5, -1};
    vecs[3] = '{"short_3",       32'h0000_0007, 10, -1, -1};
    vecs[4] = '{"exact_4",       32'h0000_000F, 10,  0, -1};
    vecs[5] = '{"release_bounce",32'h0000_0BFF, 16,  0, -1};
    vecs[6] = '{"two_presses",   32'h03FC_00FF, 26,  0, 18};

    rst_a = 1'b0;
    rst_b = 1'b0;
    btn_a = 1'b0;
    btn_b = 1'b0;

    // Reset values held while reset is low.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_y_a",     {31'd0, y_a},     32'd1);
      check("rst_pulse_a", {31'd0, pulse_a}, 32'd0);
      check("rst_db_a",    {31'd0, db_a},    32'd0);
      check("rst_y_b",     {31'd0, y_b},     32'd0);
    end
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;

    foreach (vecs[k]) apply_vec(vecs[k]);

    // Clean press with exact btn_db timing on press and release.
    @(negedge clk);
    c = cyc;
    push_a(c + LAT_A);
    btn_a = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("press_db_early", {31'd0, db_a}, 32'd0);
    check("press_y_early",  {31'd0, y_a},  {31'd0, ~exp_y_a});
    @(posedge clk);
    #1;
    check("press_db_edge6", {31'd0, db_a}, 32'd1);
    @(posedge clk);
    #1;
    check("press_pulse_off", {31'd0, pulse_a}, 32'd0);
    repeat (13) @(posedge clk);
    @(negedge clk);
    btn_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("release_db_early", {31'd0, db_a}, 32'd1);
    @(posedge clk);
    #1;
    check("release_db_edge6", {31'd0, db_a}, 32'd0);
    check("release_y_kept",   {31'd0, y_a},  {31'd0, exp_y_a});
    check("press_missing",    q_a.size(),    32'd0);
    repeat (5) @(negedge clk);

    // Reset during a press debounce, then release reset with button held.
    @(negedge clk);
    btn_a = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst_a   = 1'b0;
    exp_y_a = 1'b1;
    #1;
    check("midrst_y",     {31'd0, y_a},     32'd1);
    check("midrst_db",    {31'd0, db_a},    32'd0);
    check("midrst_pulse", {31'd0, pulse_a}, 32'd0);
    repeat (2) @(negedge clk);
    d = cyc;
    push_a(d + LAT_A);
    rst_a = 1'b1;
    repeat (15) @(negedge clk);
    btn_a = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_missing", q_a.size(), 32'd0);
    check("midrst_y_final", {31'd0, y_a}, {31'd0, exp_y_a});

    // Parameter sweep instance: toggle on edge 11, 7-cycle pulse rejected.
    @(negedge clk);
    c = cyc;
    push_b(c + LAT_B);
    btn_b = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("b_y_early",  {31'd0, y_b},  32'd0);
    check("b_db_early", {31'd0, db_b}, 32'd0);
    @(posedge clk);
    #1;
    check("b_y_edge11",  {31'd0, y_b},  32'd1);
    check("b_db_edge11", {31'd0, db_b}, 32'd1);
    repeat (9) @(negedge clk);
    btn_b = 1'b0;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      btn_b = 1'b1;
      @(negedge clk);
    end
    btn_b = 1'b0;
    repeat (30) @(negedge clk);
    check("b_y_final",  {31'd0, y_b},  32'd1);
    check("b_db_final", {31'd0, db_b}, 32'd0);
    check("b_missing",  q_b.size(),    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: actual=running required=finished cyc=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
